intr_gen: RTL and testbench

Interrupt-request source for the soft-processor system's 2-bit interrupt PIO input, replacing the constant tie-off with real events. Each channel synchronizes and debounces a raw push-button, detects the press edge, and raises a sticky level interrupt. The interrupt holds until software clears it through a PIO output bit. A second press while the interrupt is still pending is flagged as overflow. Sits in fpga_top between the board keys and the system's pio_intr export.

---
 rtl/intr_gen_pkg.sv | 8 +
 rtl/intr_gen_key_debounce.sv | 39 +++
 rtl/intr_gen.sv | 44 ++++
 tb/tb_intr_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/intr_gen_pkg.sv
// intr_gen_pkg: shared debounce timing and key polarity constants.
package intr_gen_pkg;
  localparam int CLK_FREQ_HZ = 125_000_000;
  localparam int DEB_MS = 10;
  localparam int DEB_CYC_DEF = CLK_FREQ_HZ / 1000 * DEB_MS;
  localparam int CNT_W_DEF = $clog2(DEB_CYC_DEF + 1);
  localparam logic KEY_ACT_DEF = 1'b0;
endpackage

// File: rtl/intr_gen_key_debounce.sv
// key_debounce: two-flop synchronizer, stable-level debouncer and press pulse for one key.
module key_debounce
  import intr_gen_pkg::*;
#(
  parameter int   DEB_CYC = DEB_CYC_DEF,
  parameter int   CNT_W   = CNT_W_DEF,
  parameter logic KEY_ACT = KEY_ACT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic state_o,
  output logic press_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYC - 1);
  logic [1:0] sync_q;
  logic state_q, state_d, prev_q, sync;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign sync = sync_q[1] == KEY_ACT;
  always_comb begin
    state_d = (sync != state_q && cnt_q == LAST) ? sync : state_q;
    cnt_d = (sync == state_q || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{~KEY_ACT}};
      state_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], key_i};
      state_q <= state_d;
      prev_q <= state_q;
      cnt_q <= cnt_d;
    end
  end
  assign state_o = state_q;
  assign press_o = state_q & ~prev_q;
endmodule

// File: rtl/intr_gen.sv
// intr_gen: debounced key press events raising sticky, software-cleared interrupts with overflow flags.
module intr_gen
  import intr_gen_pkg::*;
#(
  parameter int   CH_NUM  = 2,
  parameter int   DEB_CYC = DEB_CYC_DEF,
  parameter int   CNT_W   = CNT_W_DEF,
  parameter logic KEY_ACT = KEY_ACT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] key_in,
  input  logic [CH_NUM-1:0] intr_clr,
  output logic [CH_NUM-1:0] intr,
  output logic [CH_NUM-1:0] intr_ovf,
  output logic [CH_NUM-1:0] key_state
);
  logic [CH_NUM-1:0] press, intr_q, intr_d, ovf_q, ovf_d;
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    key_debounce #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W), .KEY_ACT(KEY_ACT)) u_deb (
      .clk(clk),
      .rst(rst),
      .key_i(key_in[i]),
      .state_o(key_state[i]),
      .press_o(press[i])
    );
  end
  // A press always wins over a simultaneous clear so no event is lost.
  always_comb begin
    intr_d = (intr_q & ~intr_clr) | press;
    ovf_d = (ovf_q & ~(intr_clr & ~press)) | (press & intr_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intr_q <= '0;
      ovf_q <= '0;
    end else begin
      intr_q <= intr_d;
      ovf_q <= ovf_d;
    end
  end
  assign intr = intr_q;
  assign intr_ovf = ovf_q;
endmodule

// File: tb/tb_intr_gen.sv
// tb_intr_gen: directed scenarios against a window-based debounce/interrupt model plus literal checkpoints.
module tb_intr_gen;
  localparam int DEB = 4;
  localparam logic KEY_ACT = 1'b0;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] key_in = 2'b11, intr_clr = 2'b00;
  logic [1:0] intr, intr_ovf, key_state;
  int tests = 0, fails = 0;

  intr_gen #(.CH_NUM(2), .DEB_CYC(DEB), .CNT_W(3), .KEY_ACT(KEY_ACT)) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .intr_clr(intr_clr),
    .intr(intr),
    .intr_ovf(intr_ovf),
    .key_state(key_state)
  );

  always #5 clk = ~clk;

  // Model: hist holds pressed samples, bit 0 newest; the synchronized level seen
  // before edge n is the sample taken two edges earlier (bit 2). The stable level
  // flips once the last DEB synchronized samples all disagree with it.
  logic [31:0] hist [2];
  logic [1:0] m_ks, m_rise, m_intr, m_ovf;
  always @(posedge clk or posedge rst) begin
    logic [31:0] h;
    logic flip, ev;
    if (rst) begin
      hist[0] <= '0;
      hist[1] <= '0;
      m_ks <= '0;
      m_rise <= '0;
      m_intr <= '0;
      m_ovf <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        h = {hist[c][30:0], key_in[c] == KEY_ACT};
        flip = 1'b1;
        for (int i = 2; i < DEB + 2; i++) if (h[i] == m_ks[c]) flip = 1'b0;
        ev = m_rise[c];
        hist[c] <= h;
        m_ks[c] <= m_ks[c] ^ flip;
        m_rise[c] <= flip & ~m_ks[c];
        if (ev && m_intr[c]) m_ovf[c] <= 1'b1;
        else if (ev) m_intr[c] <= 1'b1;
        else if (intr_clr[c]) begin
          m_intr[c] <= 1'b0;
          m_ovf[c] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string n, input logic [1:0] a, input logic [1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_intr", intr, m_intr);
    chk("model_ovf", intr_ovf, m_ovf);
    chk("model_key_state", key_state, m_ks);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    key_in = 2'b00;
    tick(3);
    chk("rst_intr", intr, 2'b00);
    chk("rst_ovf", intr_ovf, 2'b00);
    chk("rst_key_state", key_state, 2'b00);
    rst = 1'b0;
    tick(5);
    chk("rel_ks_early", key_state, 2'b00);
    tick(1);
    chk("rel_ks", key_state, 2'b11);
    chk("rel_intr_early", intr, 2'b00);
    tick(1);
    chk("rel_intr", intr, 2'b11);
    key_in = 2'b11;
    tick(8);
    chk("release_ks", key_state, 2'b00);
    chk("release_intr_held", intr, 2'b11);
    intr_clr = 2'b01;
    tick(1);
    intr_clr = 2'b00;
    chk("clr0", intr, 2'b10);
    intr_clr = 2'b10;
    tick(1);
    intr_clr = 2'b00;
    chk("clr1", intr, 2'b00);
    for (int r = 0; r < 5; r++) begin
      key_in[0] = 1'b0;
      tick(3);
      key_in[0] = 1'b1;
      tick(1);
    end
    tick(4);
    chk("bounce_ks", key_state, 2'b00);
    chk("bounce_intr", intr, 2'b00);
    key_in[0] = 1'b0;
    tick(5);
    chk("hold_intr_early", intr, 2'b00);
    tick(1);
    chk("hold_ks", key_state, 2'b01);
    chk("hold_intr_not_yet", intr, 2'b00);
    tick(1);
    chk("hold_intr", intr, 2'b01);
    key_in[0] = 1'b1;
    tick(8);
    key_in[1] = 1'b0;
    tick(7);
    chk("ovf_first", intr, 2'b11);
    key_in[1] = 1'b1;
    tick(8);
    key_in[1] = 1'b0;
    tick(7);
    chk("ovf_intr", intr, 2'b11);
    chk("ovf_flag", intr_ovf, 2'b10);
    key_in = 2'b11;
    tick(8);
    intr_clr = 2'b10;
    tick(1);
    intr_clr = 2'b00;
    chk("ovf_clr_intr", intr, 2'b01);
    chk("ovf_clr_flag", intr_ovf, 2'b00);
    intr_clr = 2'b01;
    tick(1);
    intr_clr = 2'b00;
    chk("clr_all", intr, 2'b00);
    intr_clr = 2'b01;
    key_in[0] = 1'b0;
    tick(6);
    chk("coll_pre", intr, 2'b00);
    tick(1);
    chk("coll_set", intr, 2'b01);
    tick(1);
    chk("coll_clr", intr, 2'b00);
    key_in[0] = 1'b1;
    tick(8);
    intr_clr = 2'b00;
    chk("coll_end", intr, 2'b00);
    chk("coll_ovf", intr_ovf, 2'b00);
    key_in[1] = 1'b0;
    tick(7);
    key_in[1] = 1'b1;
    tick(8);
    chk("mid_pre", intr, 2'b10);
    key_in[0] = 1'b0;
    tick(4);
    #2 rst = 1'b1;
    #1 chk("mid_rst_intr", intr, 2'b00);
    chk("mid_rst_ovf", intr_ovf, 2'b00);
    chk("mid_rst_ks", key_state, 2'b00);
    tick(2);
    rst = 1'b0;
    tick(3);
    key_in[0] = 1'b1;
    tick(10);
    chk("short_ks", key_state, 2'b00);
    chk("short_intr", intr, 2'b00);
    key_in[0] = 1'b0;
    tick(5);
    chk("full_ks_early", key_state, 2'b00);
    tick(1);
    chk("full_ks", key_state, 2'b01);
    tick(1);
    chk("full_intr", intr, 2'b01);
    key_in[0] = 1'b1;
    tick(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
